// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

  localparam int PS2_ENTRY_W = $bits(ps2_entry_t);

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_scan_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and drop flag.
module ps2_scan_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                       clock50,
  input  logic                       reset,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic                       rd_valid_o,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty, full, do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);

  // A pop frees the slot on the same edge, so a full FIFO still accepts a push then.
  assign do_pop  = rd_en_i && !empty;
  assign do_push = wr_en_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock50) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock50) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_valid_o = !empty;
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign overflow_o = wr_en_i && full && !do_pop;

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: input synchroniser, glitch filter, frame FSM with
// timeout, E0/F0 prefix folding and a FWFT event FIFO, all on clock50.
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int DECODE_PREFIX  = 1
) (
  input  logic                            clock50,
  input  logic                            reset,
  input  logic                            ps2_clk,
  input  logic                            ps2_dat,
  input  logic                            rd_en,
  output logic                            code_valid,
  output logic [7:0]                      code,
  output logic                            code_break,
  output logic                            code_ext,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overflow,
  output logic [1:0]                      dbg_state
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYCLES);
  localparam bit DECODE = (DECODE_PREFIX != 0);

  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic fall_q, fall_d;

  always_ff @(posedge clock50) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_dat;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Any sample matching the current filtered level restarts the run count.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FILT_LAST) begin
        filt_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    fall_d = filt_q && !filt_d;
  end

  always_ff @(posedge clock50) begin
    if (reset) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
      fall_q <= 1'b0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
      fall_q <= fall_d;
    end
  end

  ps2_state_t    state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic          timeout;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic          push_q, push_d;
  ps2_entry_t    entry_q, entry_d;
  logic          perr_q, perr_d, ferr_q, ferr_d;

  assign timeout = (state_q != IDLE) && !fall_q && (to_q == TO_LIMIT);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    to_d    = to_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    push_d  = 1'b0;
    entry_d = entry_q;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;

    if (state_q == IDLE || fall_q) begin
      to_d = '0;
    end else if (to_q != TO_LIMIT) begin
      to_d = to_q + 1'b1;
    end

    if (timeout) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end else if (fall_q) begin
      case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            bit_d   = '0;
            state_d = DATA;
          end
        end
        DATA: begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          // A bad stop bit outranks a parity failure: only one pulse per frame.
          if (!dat_s2_q) begin
            ferr_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end else if (!ps2_parity_ok(shift_q, par_q)) begin
            perr_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end else if (DECODE && shift_q == PS2_PREFIX_EXT) begin
            ext_d = 1'b1;
          end else if (DECODE && shift_q == PS2_PREFIX_BRK) begin
            brk_d = 1'b1;
          end else begin
            push_d       = 1'b1;
            entry_d.ext  = ext_q;
            entry_d.brk  = brk_q;
            entry_d.code = shift_q;
            ext_d        = 1'b0;
            brk_d        = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock50) begin
    if (reset) begin
      state_q <= IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      to_q    <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      push_q  <= 1'b0;
      entry_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      to_q    <= to_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      push_q  <= push_d;
      entry_q <= entry_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Consumer handshake: code_valid acts as valid and rd_en as ready; the head
  // entry is popped on any edge where both are high, and rd_en alone is ignored.
  logic [PS2_ENTRY_W-1:0] head_bits;
  ps2_entry_t             head;
  logic                   head_valid;

  ps2_scan_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_ENTRY_W)
  ) u_fifo (
    .clock50    (clock50),
    .reset      (reset),
    .wr_en_i    (push_q),
    .wr_data_i  (entry_q),
    .rd_en_i    (rd_en),
    .rd_valid_o (head_valid),
    .rd_data_o  (head_bits),
    .count_o    (fifo_count),
    .overflow_o (overflow)
  );

  assign head       = ps2_entry_t'(head_bits);
  assign code_valid = head_valid;
  assign code       = head_valid ? head.code : 8'h00;
  assign code_break = head_valid && head.brk;
  assign code_ext   = head_valid && head.ext;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: bit-banged PS/2 frames, immediate-assertion checks.
module tb_ps2_scan_receiver;
  localparam int FILTER_LEN     = 4;
  localparam int FIFO_DEPTH     = 4;
  localparam int TIMEOUT_CYCLES = 300;
  localparam int H              = 12;
  localparam int EDGE_TO_ERR    = FILTER_LEN + 3;
  localparam int EDGE_TO_VALID  = FILTER_LEN + 4;

  logic       clock50, reset, ps2_clk, ps2_dat, rd_en;
  logic       code_valid, code_break, code_ext;
  logic [7:0] code;
  logic [2:0] fifo_count;
  logic       parity_err, frame_err, overflow;
  logic [1:0] dbg_state;

  int checks, failures;
  int cyc, fall_cyc, rise_cyc, perr_cyc, ferr_cyc;
  int perr_n, ferr_n, ovf_n;
  int perr_b, ferr_b, ovf_b;
  logic valid_prev;

  ps2_scan_receiver #(
    .FILTER_LEN     (FILTER_LEN),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .DECODE_PREFIX  (1)
  ) dut (
    .clock50    (clock50),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .rd_en      (rd_en),
    .code_valid (code_valid),
    .code       (code),
    .code_break (code_break),
    .code_ext   (code_ext),
    .fifo_count (fifo_count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clock50 = 1'b0;
  always #10 clock50 = ~clock50;
  always @(posedge clock50) cyc++;

  // Pulse monitor: counts high cycles of each pulse and records timestamps
  always @(negedge clock50) begin
    if (parity_err) begin perr_n++; perr_cyc = cyc; end
    if (frame_err)  begin ferr_n++; ferr_cyc = cyc; end
    if (overflow)   ovf_n++;
    if (code_valid && !valid_prev) rise_cyc = cyc;
    valid_prev = code_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [7:0] c, input logic brk, input logic ext);
    check({tag, ".valid"}, 32'(code_valid), 32'd1);
    check({tag, ".code"},  32'(code),       32'(c));
    check({tag, ".brk"},   32'(code_break), 32'(brk));
    check({tag, ".ext"},   32'(code_ext),   32'(ext));
  endtask

  task automatic snap();
    perr_b = perr_n;
    ferr_b = ferr_n;
    ovf_b  = ovf_n;
  endtask

  // Driver tasks
  task automatic bit_out(input logic b, input logic pop_at_push);
    ps2_dat = b;
    repeat (H) @(negedge clock50);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    if (pop_at_push) begin
      repeat (EDGE_TO_ERR) @(negedge clock50);
      rd_en = 1'b1;
      @(negedge clock50);
      rd_en = 1'b0;
      repeat (H - EDGE_TO_ERR - 1) @(negedge clock50);
    end else begin
      repeat (H) @(negedge clock50);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                            input logic pop_at_push);
    bit_out(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i], 1'b0);
    bit_out((~^b) ^ bad_par, 1'b0);
    bit_out(stop, pop_at_push);
    ps2_dat = 1'b1;
    repeat (H) @(negedge clock50);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clock50);
    rd_en = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    perr_n = 0; ferr_n = 0; ovf_n = 0; valid_prev = 1'b0;
    fall_cyc = 0; rise_cyc = 0; perr_cyc = 0; ferr_cyc = 0;
    reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; rd_en = 1'b0;
    repeat (5) @(negedge clock50);

    // Reset state
    check("rst.valid", 32'(code_valid), 32'd0);
    check("rst.code",  32'(code),       32'd0);
    check("rst.brk",   32'(code_break), 32'd0);
    check("rst.ext",   32'(code_ext),   32'd0);
    check("rst.count", 32'(fifo_count), 32'd0);
    check("rst.perr",  32'(parity_err), 32'd0);
    check("rst.ferr",  32'(frame_err),  32'd0);
    check("rst.ovf",   32'(overflow),   32'd0);
    check("rst.state", 32'(dbg_state),  32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clock50);

    // Single keypress 1C
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("single.latency", 32'(rise_cyc - fall_cyc), 32'(EDGE_TO_VALID));
    check("single.count", 32'(fifo_count), 32'd1);
    check_head("single", 8'h1C, 1'b0, 1'b0);
    check("single.noerr", 32'(perr_n + ferr_n - perr_b - ferr_b), 32'd0);
    pop();
    check("single.popped", 32'(code_valid), 32'd0);
    check("single.count0", 32'(fifo_count), 32'd0);

    // Prefixed release E0 F0 75, then plain 1C
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    check("pfx.noentry", 32'(fifo_count), 32'd0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    check("pfx.count", 32'(fifo_count), 32'd1);
    check_head("pfx", 8'h75, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("pfx.count2", 32'(fifo_count), 32'd2);
    pop();
    check_head("pfx.plain", 8'h1C, 1'b0, 1'b0);
    pop();
    check("pfx.empty", 32'(code_valid), 32'd0);

    // Parity error with pending F0
    snap();
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check("perr.pulses", 32'(perr_n - perr_b), 32'd1);
    check("perr.timing", 32'(perr_cyc - fall_cyc), 32'(EDGE_TO_ERR));
    check("perr.noferr", 32'(ferr_n - ferr_b), 32'd0);
    check("perr.noentry", 32'(fifo_count), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check_head("perr.after", 8'h1C, 1'b0, 1'b0);
    pop();

    // Stop-bit error with pending F0
    snap();
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check("ferr.pulses", 32'(ferr_n - ferr_b), 32'd1);
    check("ferr.timing", 32'(ferr_cyc - fall_cyc), 32'(EDGE_TO_ERR));
    check("ferr.noperr", 32'(perr_n - perr_b), 32'd0);
    check("ferr.noentry", 32'(fifo_count), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check_head("ferr.after", 8'h1C, 1'b0, 1'b0);
    pop();

    // Stall after 4 data bits
    snap();
    bit_out(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b1, 1'b0);
    check("stall.in_data", 32'(dbg_state), 32'd1);
    repeat (TIMEOUT_CYCLES + 100) @(negedge clock50);
    check("stall.ferr", 32'(ferr_n - ferr_b), 32'd1);
    check("stall.idle", 32'(dbg_state), 32'd0);
    check("stall.noentry", 32'(fifo_count), 32'd0);
    send_frame(8'h2A, 1'b0, 1'b1, 1'b0);
    check_head("stall.after", 8'h2A, 1'b0, 1'b0);
    pop();

    // Overflow on the fifth push
    snap();
    send_frame(8'h16, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1E, 1'b0, 1'b1, 1'b0);
    send_frame(8'h26, 1'b0, 1'b1, 1'b0);
    send_frame(8'h25, 1'b0, 1'b1, 1'b0);
    check("ovf.count4", 32'(fifo_count), 32'd4);
    check("ovf.none_yet", 32'(ovf_n - ovf_b), 32'd0);
    send_frame(8'h2E, 1'b0, 1'b1, 1'b0);
    check("ovf.count_full", 32'(fifo_count), 32'd4);
    check("ovf.pulse", 32'(ovf_n - ovf_b), 32'd1);
    check_head("ovf.h0", 8'h16, 1'b0, 1'b0);
    pop();
    check_head("ovf.h1", 8'h1E, 1'b0, 1'b0);
    pop();
    check_head("ovf.h2", 8'h26, 1'b0, 1'b0);
    pop();
    check_head("ovf.h3", 8'h25, 1'b0, 1'b0);
    pop();
    check("ovf.drained", 32'(code_valid), 32'd0);
    check("ovf.count0", 32'(fifo_count), 32'd0);

    // Push while full with a same-cycle pop
    snap();
    send_frame(8'h15, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1D, 1'b0, 1'b1, 1'b0);
    send_frame(8'h24, 1'b0, 1'b1, 1'b0);
    send_frame(8'h2D, 1'b0, 1'b1, 1'b0);
    send_frame(8'h2C, 1'b0, 1'b1, 1'b1);
    check("fullpop.count", 32'(fifo_count), 32'd4);
    check("fullpop.noovf", 32'(ovf_n - ovf_b), 32'd0);
    check_head("fullpop.h0", 8'h1D, 1'b0, 1'b0);
    pop();
    check_head("fullpop.h1", 8'h24, 1'b0, 1'b0);
    pop();
    check_head("fullpop.h2", 8'h2D, 1'b0, 1'b0);
    pop();
    check_head("fullpop.h3", 8'h2C, 1'b0, 1'b0);
    pop();
    check("fullpop.empty", 32'(code_valid), 32'd0);

    // Reset mid-frame with an entry already queued
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    bit_out(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) bit_out(1'b1, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clock50);
    reset = 1'b0;
    @(negedge clock50);
    check("midrst.valid", 32'(code_valid), 32'd0);
    check("midrst.count", 32'(fifo_count), 32'd0);
    check("midrst.code",  32'(code),       32'd0);
    check("midrst.state", 32'(dbg_state),  32'd0);
    repeat (TIMEOUT_CYCLES + 20) @(negedge clock50);
    check("midrst.noerr", 32'(perr_n + ferr_n - perr_b - ferr_b), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    check("midrst.count1", 32'(fifo_count), 32'd1);
    check_head("midrst.after", 8'h5A, 1'b0, 1'b0);
    pop();

    // Raw-clock glitch shorter than the filter length, with data low
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    repeat (FILTER_LEN - 1) @(negedge clock50);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clock50);
    ps2_dat = 1'b1;
    check("glitch.idle", 32'(dbg_state), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("glitch.count", 32'(fifo_count), 32'd1);
    check_head("glitch.after", 8'h1C, 1'b0, 1'b0);
    pop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
